// File: rtl/pin_cmd_responder.sv
// Byte command responder: NOP/WRITE/READ/STATUS commands on a valid/ready input channel, responses on a valid/ready output.
// Define CMD_PARITY_EN to require odd parity (^{in_parity,in_data}==1) on every accepted byte.
module pin_cmd_responder #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_parity,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);
    localparam int unsigned NREGS = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    // Command bits between the address field and the opcode must be zero.
    localparam logic [5:0] RSV_MASK = 6'h3F << ADDR_W;

    logic [1:0]        state;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        regs [NREGS];
    logic [3:0]        err_cnt;
    logic              resp_status;

    logic              parity_ok;
    logic              accept;
    logic              take;
    logic              byte_err;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef CMD_PARITY_EN
    assign parity_ok = ^{in_parity, in_data};
`else
    logic unused_parity;
    assign unused_parity = in_parity;
    assign parity_ok     = 1'b1;
`endif

    assign op   = in_data[7:6];
    assign addr = in_data[ADDR_W-1:0];

    assign in_ready  = ena && !rst && ((state == ST_IDLE) || (state == ST_WDATA));
    assign out_valid = (state == ST_RESP);

    assign accept = in_valid && in_ready;
    assign take   = ena && out_valid && out_ready;

    // Write data is never decoded, so only command bytes can trip the reserved-bit check.
    assign byte_err = accept &&
                      (!parity_ok || ((state == ST_IDLE) && |(in_data[5:0] & RSV_MASK)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            waddr       <= '0;
            out_data    <= 8'h00;
            err         <= 1'b0;
            err_cnt     <= 4'h0;
            resp_status <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i[ADDR_W-1:0]] <= RST_VAL;
            end
        end else if (ena) begin
            if (byte_err) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
            end else if (accept) begin
                case (state)
                    ST_IDLE: begin
                        case (op)
                            OP_WRITE: begin
                                waddr <= addr;
                                state <= ST_WDATA;
                            end
                            OP_READ: begin
                                out_data    <= regs[addr];
                                resp_status <= 1'b0;
                                state       <= ST_RESP;
                            end
                            OP_STATUS: begin
                                out_data    <= {err, 3'b000, err_cnt};
                                resp_status <= 1'b1;
                                state       <= ST_RESP;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    ST_WDATA: begin
                        regs[waddr] <= in_data;
                        state       <= ST_IDLE;
                    end
                    default: state <= state;
                endcase
            end else if (take) begin
                state <= ST_IDLE;
                if (resp_status) begin
                    err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pin_cmd_responder.sv
// Randomised scoreboard bench for pin_cmd_responder with a byte-level reference model of the command protocol.
module tb_pin_cmd_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_parity;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    pin_cmd_responder dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_data(in_data), .in_valid(in_valid), .in_parity(in_parity), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    // Reference model state
    logic [7:0] m_mem [16];
    logic       m_err;
    logic [3:0] m_cnt;
    logic       m_wpend;
    logic [3:0] m_waddr;
    logic [7:0] q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic gp(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic par_ok(input logic [7:0] b, input logic p);
`ifdef CMD_PARITY_EN
        return ^{p, b};
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_err = 1'b0;
        m_cnt = 4'h0;
        m_wpend = 1'b0;
        m_waddr = 4'h0;
        q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p);
        int n;
        in_data = b;
        in_parity = p;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
                $fatal(1, "input handshake timed out");
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends one byte and applies the command-protocol rules to the model.
    task automatic issue(input logic [7:0] b, input logic p);
        logic bad;
        send_byte(b, p);
        bad = !par_ok(b, p) || (!m_wpend && (b[5:4] != 2'b00));
        if (bad) begin
            m_err = 1'b1;
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
        end else if (m_wpend) begin
            m_mem[m_waddr] = b;
            m_wpend = 1'b0;
        end else begin
            case (b[7:6])
                2'b01: begin m_wpend = 1'b1; m_waddr = b[3:0]; end
                2'b10: q.push_back(m_mem[b[3:0]]);
                2'b11: begin q.push_back({m_err, 3'b000, m_cnt}); m_err = 1'b0; end
                default: ;
            endcase
        end
    endtask

    task automatic drain();
        int n;
        rdy_mode = 1;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", {31'd0, (q.size() == 0 && !out_valid)}, 32'd1);
    endtask

    task automatic read_check(input string nm, input logic [7:0] b, input logic [7:0] expv);
        issue(b, gp(b));
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(nm, {24'd0, out_data}, {24'd0, expv});
        drain();
    endtask

    task automatic do_rst();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
    endtask

    task automatic freeze(input int k);
        logic ov;
        logic [7:0] od;
        ov = out_valid;
        od = out_data;
        ena = 1'b0;
        in_valid = 1'b1;
        in_data = 8'($urandom);
        in_parity = gp(in_data);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("frz_in_ready", {31'd0, in_ready}, 32'd0);
            chk("frz_out_valid", {31'd0, out_valid}, {31'd0, ov});
            chk("frz_out_data", {24'd0, out_data}, {24'd0, od});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ena = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && ena && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp_unexpected: got %0h expected none", out_data);
            end else begin
                chk("resp_data", {24'd0, out_data}, {24'd0, q.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic [3:0] a;
        logic       p;
        int         r;
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_parity = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_rst();
        repeat (3) @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_err", {31'd0, err}, 32'd0);
        chk("idle_out_data", {24'd0, out_data}, 32'h00);

        // Write then read back with latency of one edge
        @(posedge clk); #1;
        rdy_mode = 1; out_ready = 1'b1;
        issue(8'h43, gp(8'h43));
        issue(8'hA5, gp(8'hA5));
        read_check("raw_read", 8'h83, 8'hA5);

        // Response held while out_ready is low
        rdy_mode = 0; out_ready = 1'b0;
        issue(8'h81, gp(8'h81));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {24'd0, out_data}, 32'h00);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();
        @(negedge clk);
        chk("hold_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reserved bits, STATUS clear-on-read
        @(posedge clk); #1;
        do_rst();
        issue(8'h70, gp(8'h70));
        chk("rsv_err", {31'd0, err}, 32'd1);
        rdy_mode = 1; out_ready = 1'b1;
        read_check("rsv_nowrite", 8'h80, 8'h00);
        read_check("status1", 8'hC0, 8'h81);
        read_check("status2", 8'hC0, 8'h01);

        // Error counter saturation
        for (int i = 0; i < 17; i++) issue(8'h70, gp(8'h70));
        read_check("status_sat", 8'hC0, 8'h8F);

`ifdef CMD_PARITY_EN
        do_rst();
        issue(8'h83, 1'b1);
        chk("par_err", {31'd0, err}, 32'd1);
        chk("par_dropped", {31'd0, out_valid}, 32'd0);
        rdy_mode = 1; out_ready = 1'b1;
        issue(8'h83, 1'b0);
        chk("par_ok_valid", {31'd0, out_valid}, 32'd1);
        chk("par_ok_data", {24'd0, out_data}, 32'h00);
        drain();
`endif

        // Reset mid-transaction abandons write and pending response
        issue(8'h45, gp(8'h45));
        do_rst();
        rdy_mode = 1; out_ready = 1'b1;
        issue(8'h35, gp(8'h35));
        read_check("rst_abandon_write", 8'h85, 8'h00);
        issue(8'h42, gp(8'h42));
        issue(8'h3C, gp(8'h3C));
        rdy_mode = 0; out_ready = 1'b0;
        issue(8'h82, gp(8'h82));
        repeat (2) @(posedge clk);
        #1;
        do_rst();
        chk("rst_discard_valid", {31'd0, out_valid}, 32'd0);

        // Randomised traffic
        rdy_mode = 2;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            a = 4'($urandom);
            b = 8'($urandom);
            p = gp(b);
`ifdef CMD_PARITY_EN
            if ($urandom_range(0, 7) == 0) p = ~p;
`else
            p = 1'($urandom);
`endif
            case (r)
                0, 1, 2: begin
                    issue({2'b01, 2'b00, a}, gp({2'b01, 2'b00, a}));
                    issue(b, p);
                end
                3, 4, 5: issue({2'b10, 2'b00, a}, gp({2'b10, 2'b00, a}));
                6: issue({2'b11, 2'b00, a}, gp({2'b11, 2'b00, a}));
                7: begin
                    b = {b[7:6], 2'($urandom_range(1, 3)), a};
                    issue(b, gp(b));
                end
                8: issue({2'b00, 2'b00, a}, p);
                default: freeze($urandom_range(1, 4));
            endcase
        end
        drain();
        chk("final_queue_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
